// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   N_VEC  : number of input vectors of a 4-input function (16)
//   VEC_W  : vector width / index width (4)
//   CNT_W  : width of the mismatch count (holds 0..16)
//   state_e: scanner FSM states
package truth_table_scanner_pkg;
    localparam int N_VEC = 16;
    localparam int VEC_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/tt_compare.sv
// Combinational compare of a captured truth table against a golden table.
//   table_in   : captured table, bit i = f for vector i
//   expected   : golden table
//   match      : tables identical
//   fail_cnt   : number of differing bits (0..16)
//   first_fail : lowest differing index, 0 when the tables match
module tt_compare
    import truth_table_scanner_pkg::*;
(
    input  logic [N_VEC-1:0] table_in,
    input  logic [N_VEC-1:0] expected,
    output logic             match,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [VEC_W-1:0] first_fail
);
    logic [N_VEC-1:0] diff;

    always_comb begin
        diff       = table_in ^ expected;
        fail_cnt   = '0;
        first_fail = '0;
        // Walk from the top down so the last hit written is the lowest index.
        for (int i = N_VEC - 1; i >= 0; i--) begin
            fail_cnt = fail_cnt + {{(CNT_W-1){1'b0}}, diff[i]};
            if (diff[i]) first_fail = VEC_W'(i);
        end
        match = (diff == '0);
    end
endmodule

// File: rtl/truth_table_scanner.sv
// Exhaustively drives all 16 input vectors into a 4-input combinational
// function, captures its truth table and compares it with a golden table.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : scan request, honoured only in IDLE
//   expected   : golden truth table
//   f_in       : output of the function under test
//   a,b,c,d    : vector driven to the function, {a,b,c,d} = idx
//   busy       : scan in progress (DRIVE)
//   done       : one-cycle pulse at end of scan
//   table_out  : captured truth table
//   match, fail_cnt, first_fail : compare results, valid from the DONE cycle
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int SETTLE = 1    // cycles each vector is held, 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_VEC-1:0] expected,
    input  logic             f_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_out,
    output logic             match,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [VEC_W-1:0] first_fail
);
    state_e           state;
    logic [VEC_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic             last_settle;
    logic [N_VEC-1:0] table_next;
    logic             cmp_match;
    logic [CNT_W-1:0] cmp_fail_cnt;
    logic [VEC_W-1:0] cmp_first_fail;

    assign last_settle = (settle_cnt == 4'(SETTLE - 1));

    // The final sample lands on the same edge that enters DONE, so compare
    // against the table including the bit being captured now; that makes the
    // results valid in the DONE cycle itself.
    always_comb begin
        table_next      = table_out;
        table_next[idx] = f_in;
    end

    tt_compare u_cmp (
        .table_in   (table_next),
        .expected   (expected),
        .match      (cmp_match),
        .fail_cnt   (cmp_fail_cnt),
        .first_fail (cmp_first_fail)
    );

    // Outputs decode from registered state only; no path from start.
    assign {a, b, c, d} = (state == ST_DRIVE) ? idx : '0;
    assign busy         = (state == ST_DRIVE);
    assign done         = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            table_out  <= '0;
            match      <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        idx        <= '0;
                        settle_cnt <= '0;
                        table_out  <= '0;
                        match      <= 1'b0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (last_settle) begin
                        table_out  <= table_next;
                        settle_cnt <= '0;
                        if (idx == VEC_W'(N_VEC - 1)) begin
                            // idx is left at 15 here and cleared on leaving DONE,
                            // so it never wraps inside a scan.
                            state      <= ST_DONE;
                            match      <= cmp_match;
                            fail_cnt   <= cmp_fail_cnt;
                            first_fail <= cmp_first_fail;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;
    localparam logic [15:0] POS_TAB = 16'h55B5;   // zeros at 1,3,6,9,11,13,15

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s [2];
    logic [15:0] exp_s   [2];
    logic [15:0] fn_s    [2];
    logic        fin_s   [2];
    logic        a_s [2], b_s [2], c_s [2], d_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [15:0] tab_s   [2];
    logic        match_s [2];
    logic [4:0]  fc_s    [2];
    logic [3:0]  ff_s    [2];
    int          st      [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Behavioural function under test: a lookup in its own truth table.
    assign fin_s[0] = fn_s[0][{a_s[0], b_s[0], c_s[0], d_s[0]}];
    assign fin_s[1] = fn_s[1][{a_s[1], b_s[1], c_s[1], d_s[1]}];

    truth_table_scanner #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .expected(exp_s[0]), .f_in(fin_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .d(d_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .table_out(tab_s[0]), .match(match_s[0]), .fail_cnt(fc_s[0]), .first_fail(ff_s[0]));

    truth_table_scanner #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .expected(exp_s[1]), .f_in(fin_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .d(d_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .table_out(tab_s[1]), .match(match_s[1]), .fail_cnt(fc_s[1]), .first_fail(ff_s[1]));

    typedef struct {
        logic [15:0] ftab;
        logic [15:0] ex;
        logic [15:0] tab;
        int          m;
        int          fc;
        int          ff;
    } vec_t;

    vec_t tv [7];

    function automatic int vec(input int u);
        return int'({a_s[u], b_s[u], c_s[u], d_s[u]});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Reference results for a scan: spec arithmetic on the two tables.
    task automatic ref_model(input logic [15:0] ftab, input logic [15:0] ex,
                             output int m, output int fc, output int ff);
        logic [15:0] diff;
        diff = ftab ^ ex;
        fc   = $countones(diff);
        m    = (fc == 0) ? 1 : 0;
        ff   = 0;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                ff = i;
                break;
            end
        end
    endtask

    // Pulse start for one cycle, wait (bounded) for done, return outputs seen
    // in the DONE cycle.
    task automatic run_scan(input int u, input logic [15:0] ftab, input logic [15:0] ex,
                            input bit chk_seq, output int lat, output logic [15:0] t,
                            output int m, output int fc, output int ff);
        fn_s[u]  = ftab;
        exp_s[u] = ex;
        @(negedge clk); start_s[u] = 1'b1;
        @(negedge clk); start_s[u] = 1'b0;
        chk("busy_after_start", int'(busy_s[u]), 1);
        lat = 0;
        while (!done_s[u] && lat < 400) begin
            if (chk_seq) chk("vec_order", vec(u), lat / st[u]);
            @(negedge clk);
            lat++;
        end
        chk("done_latency", lat, 16 * st[u]);
        chk("busy_in_done", int'(busy_s[u]), 0);
        chk("abcd_in_done", vec(u), 0);
        t  = tab_s[u];
        m  = int'(match_s[u]);
        fc = int'(fc_s[u]);
        ff = int'(ff_s[u]);
    endtask

    initial begin
        int lat, m, fc, ff, rm, rfc, rff, n, ndone;
        int d_at [2];
        logic [15:0] t, rt, re;

        st[0] = 1; st[1] = 3;
        tv[0] = '{POS_TAB, 16'h55B5, POS_TAB, 1, 0,  0};
        tv[1] = '{POS_TAB, 16'h55B4, POS_TAB, 0, 1,  0};
        tv[2] = '{POS_TAB, 16'hAA4A, POS_TAB, 0, 16, 0};
        tv[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 0,  0};
        tv[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 0, 16, 0};
        tv[5] = '{POS_TAB, 16'h55A5, POS_TAB, 0, 1,  4};
        tv[6] = '{16'h0000, 16'h8000, 16'h0000, 0, 1,  15};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0; exp_s[u] = '0; fn_s[u] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_busy",  int'(busy_s[0]), 0);
        chk("rst_done",  int'(done_s[0]), 0);
        chk("rst_abcd",  vec(0), 0);
        chk("rst_table", int'(tab_s[0]), 0);
        chk("rst_match", int'(match_s[0]), 0);
        chk("rst_fc",    int'(fc_s[0]), 0);
        chk("rst_ff",    int'(ff_s[0]), 0);

        // Table-driven scans with SETTLE=1, including the held-value check
        for (int i = 0; i < 7; i++) begin
            run_scan(0, tv[i].ftab, tv[i].ex, (i == 0), lat, t, m, fc, ff);
            chk($sformatf("tv%0d_table", i), int'(t), int'(tv[i].tab));
            chk($sformatf("tv%0d_match", i), m, tv[i].m);
            chk($sformatf("tv%0d_fc", i), fc, tv[i].fc);
            chk($sformatf("tv%0d_ff", i), ff, tv[i].ff);
            @(negedge clk);
            chk($sformatf("tv%0d_done_pulse", i), int'(done_s[0]), 0);
            chk($sformatf("tv%0d_hold_fc", i), int'(fc_s[0]), tv[i].fc);
            chk($sformatf("tv%0d_hold_match", i), int'(match_s[0]), tv[i].m);
        end

        // SETTLE=3: each vector held three cycles, done at k+49
        run_scan(1, POS_TAB, 16'h55B5, 1'b1, lat, t, m, fc, ff);
        chk("s3_table", int'(t), int'(POS_TAB));
        chk("s3_match", m, 1);

        // Reset in the middle of a scan at vector 7
        fn_s[0] = POS_TAB; exp_s[0] = 16'h55B4;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        n = 0;
        while (vec(0) != 7 && n < 100) begin
            @(negedge clk); n++;
        end
        chk("rst_mid_reach_v7", vec(0), 7);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("rstmid_busy",  int'(busy_s[0]), 0);
        chk("rstmid_abcd",  vec(0), 0);
        chk("rstmid_table", int'(tab_s[0]), 0);
        chk("rstmid_fc",    int'(fc_s[0]), 0);
        run_scan(0, POS_TAB, 16'h55B4, 1'b1, lat, t, m, fc, ff);
        chk("after_rst_table", int'(t), int'(POS_TAB));
        chk("after_rst_fc", fc, 1);

        // start pulses inside DRIVE and in the DONE cycle are ignored
        fn_s[0] = POS_TAB; exp_s[0] = 16'h55B5;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        lat = 0;
        while (!done_s[0] && lat < 100) begin
            start_s[0] = (lat == 5);
            @(negedge clk); lat++;
        end
        chk("ign_latency", lat, 16);
        start_s[0] = 1'b1;             // in the DONE cycle
        @(negedge clk); start_s[0] = 1'b0;
        chk("ign_done_busy1", int'(busy_s[0]), 0);
        @(negedge clk);
        chk("ign_done_busy2", int'(busy_s[0]), 0);

        // start held high: back-to-back scans, done every 16*SETTLE+2 cycles
        @(negedge clk); start_s[0] = 1'b1;
        n = 0; ndone = 0;
        while (ndone < 2 && n < 200) begin
            @(negedge clk); n++;
            if (done_s[0]) begin
                d_at[ndone] = n;
                ndone++;
            end
        end
        start_s[0] = 1'b0;
        chk("b2b_count", ndone, 2);
        chk("b2b_first", d_at[0], 17);
        chk("b2b_gap", d_at[1] - d_at[0], 18);
        chk("b2b_match", int'(match_s[0]), 1);
        @(negedge clk);

        // Randomized tables against the reference model
        for (int i = 0; i < 20; i++) begin
            rt = 16'($urandom);
            re = (i % 3 == 0) ? rt ^ (16'd1 << $urandom_range(15, 0)) : 16'($urandom);
            if (i % 5 == 0) re = rt;
            ref_model(rt, re, rm, rfc, rff);
            run_scan(0, rt, re, 1'b0, lat, t, m, fc, ff);
            chk($sformatf("rnd%0d_table", i), int'(t), int'(rt));
            chk($sformatf("rnd%0d_match", i), m, rm);
            chk($sformatf("rnd%0d_fc", i), fc, rfc);
            chk($sformatf("rnd%0d_ff", i), ff, rff);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
